// File: rtl/pixel_frame_ctrl.sv
// Start-triggered frame sequencer for the pixel array: erase/expose/convert/read
// phases, ADC ramp generation, frame capture and a valid/ready word stream.
module pixel_frame_ctrl #(
   parameter  int ERASE_CYCLES = 5,
   parameter  int DATA_W       = 8,
   parameter  int N_PIX        = 4,
   localparam int IDX_W        = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     continuous,
   input  logic [15:0]              exp_time,
   output logic                     erase,
   output logic                     expose,
   output logic                     convert,
   output logic                     read,
   output logic [DATA_W-1:0]        adc_count,
   input  logic [N_PIX*DATA_W-1:0]  pix_data_in,
   output logic [DATA_W-1:0]        out_data,
   output logic [IDX_W-1:0]         out_index,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [15:0]         exp_q, exp_d;
   logic [DATA_W-1:0]   adc_q, adc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                erase_q, expose_q, convert_q, read_q, busy_q;
   logic [DATA_W-1:0]   buf_q [N_PIX];
   logic [IDX_W-1:0]    idx_nxt;
   logic [15:0]         exp_sat;

   assign idx_nxt = idx_q + 1'b1;
   // A zero exposure request still yields one expose cycle.
   assign exp_sat = (exp_time == 16'd0) ? 16'd1 : exp_time;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      adc_d   = '0;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ERASE;
               cnt_d   = '0;
               exp_d   = exp_sat;
            end
         end
         S_ERASE: begin
            if (cnt_q == 16'(ERASE_CYCLES - 1)) begin
               state_d = S_EXPOSE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_EXPOSE: begin
            if (cnt_q == exp_q - 16'd1) begin
               state_d = S_CONVERT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CONVERT: begin
            if (adc_q == '1) begin
               state_d = S_READ;
            end else begin
               adc_d = adc_q + 1'b1;
            end
         end
         S_READ: begin
            state_d = S_DRAIN;
            idx_d   = '0;
            data_d  = pix_data_in[DATA_W-1:0];
            valid_d = 1'b1;
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (idx_q == IDX_W'(N_PIX - 1)) begin
                  valid_d = 1'b0;
                  data_d  = '0;
                  idx_d   = '0;
                  done_d  = 1'b1;
                  if (continuous) begin
                     state_d = S_ERASE;
                     cnt_d   = '0;
                     exp_d   = exp_sat;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d  = idx_nxt;
                  data_d = buf_q[idx_nxt];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Phase flags are registered from the next state so every output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         exp_q     <= '0;
         adc_q     <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         erase_q   <= 1'b0;
         expose_q  <= 1'b0;
         convert_q <= 1'b0;
         read_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         exp_q     <= exp_d;
         adc_q     <= adc_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         erase_q   <= (state_d == S_ERASE);
         expose_q  <= (state_d == S_EXPOSE);
         convert_q <= (state_d == S_CONVERT);
         read_q    <= (state_d == S_READ);
         busy_q    <= (state_d != S_IDLE);
      end
   end

   for (genvar gi = 0; gi < N_PIX; gi++) begin : g_capture
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            buf_q[gi] <= '0;
         end else if (state_q == S_READ) begin
            buf_q[gi] <= pix_data_in[gi*DATA_W +: DATA_W];
         end
      end
   end

   assign erase      = erase_q;
   assign expose     = expose_q;
   assign convert    = convert_q;
   assign read       = read_q;
   assign adc_count  = adc_q;
   assign out_data   = data_q;
   assign out_index  = idx_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
